calc_controller: RTL

CALC_CONTROLLER -- requirements
Module: calc_controller

---
 rtl/calc_controller.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/calc_controller.sv
// rtl/calc_controller.sv - accumulator-machine instruction sequencer FSM
module calc_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        instr_valid,
  input  logic [34:0] instr,
  input  logic        alu_ovf,
  output logic        instr_req,
  output logic [15:0] imm_a,
  output logic [15:0] imm_b,
  output logic        mux_sel,
  output logic [1:0]  alu_op,
  output logic        acc_wr_en,
  output logic        acc_clr,
  output logic        pc_wr_en,
  output logic [15:0] instr_count,
  output logic        halted,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_ADDI   = 3'b001;
  localparam logic [2:0] OP_SUBI   = 3'b010;
  localparam logic [2:0] OP_ACCADD = 3'b011;
  localparam logic [2:0] OP_ACCSUB = 3'b100;
  localparam logic [2:0] OP_CLR    = 3'b101;
  localparam logic [2:0] OP_ILL    = 3'b110;
  localparam logic [2:0] OP_HALT   = 3'b111;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  state_t      state_q;
  logic [2:0]  opcode_q;
  logic [15:0] imm_a_q;
  logic [15:0] imm_b_q;
  logic [15:0] count_q;
  logic [15:0] count_d;

  logic        is_alu_op;
  logic        in_alu_phase;
  logic        ovf_trap;
  logic        retire;

  // Classify the latched opcode and decide whether the WB cycle retires or traps.
  always_comb begin
    is_alu_op    = (opcode_q == OP_ADDI) || (opcode_q == OP_SUBI) ||
                   (opcode_q == OP_ACCADD) || (opcode_q == OP_ACCSUB);
    in_alu_phase = (state_q == S_EXEC) || (state_q == S_WB);
    ovf_trap     = (state_q == S_WB) && is_alu_op && alu_ovf;
    retire       = (state_q == S_WB) && !ovf_trap;
    count_d      = count_q + 16'd1;
  end

  // Datapath controls follow the opcode only while the ALU result is in flight.
  always_comb begin
    mux_sel = 1'b0;
    alu_op  = ALU_PASS;
    if (in_alu_phase) begin
      case (opcode_q)
        OP_ADDI:   begin mux_sel = 1'b1; alu_op = ALU_ADD; end
        OP_SUBI:   begin mux_sel = 1'b1; alu_op = ALU_SUB; end
        OP_ACCADD: begin mux_sel = 1'b0; alu_op = ALU_ADD; end
        OP_ACCSUB: begin mux_sel = 1'b0; alu_op = ALU_SUB; end
        default:   begin mux_sel = 1'b0; alu_op = ALU_PASS; end
      endcase
    end
  end

  // Strobes are single WB-cycle pulses; overflow must veto them in the same cycle.
  always_comb begin
    acc_wr_en = (state_q == S_WB) && is_alu_op && !alu_ovf;
    acc_clr   = (state_q == S_WB) && (opcode_q == OP_CLR);
    pc_wr_en  = retire;
  end

  assign instr_req   = (state_q == S_FETCH);
  assign halted      = (state_q == S_HALT);
  assign error       = (state_q == S_ERR);
  assign imm_a       = imm_a_q;
  assign imm_b       = imm_b_q;
  assign instr_count = count_q;

  // Sequencer: state, latched instruction fields and the retired counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= OP_NOP;
      imm_a_q  <= 16'h0000;
      imm_b_q  <= 16'h0000;
      count_q  <= 16'h0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (instr_valid) begin
            opcode_q <= instr[34:32];
            imm_a_q  <= instr[31:16];
            imm_b_q  <= instr[15:0];
            state_q  <= S_DECODE;
          end else if (!run) begin
            state_q <= S_IDLE;
          end
        end
        S_DECODE: begin
          if (opcode_q == OP_ILL)       state_q <= S_ERR;
          else if (opcode_q == OP_HALT) state_q <= S_HALT;
          else                          state_q <= S_EXEC;
        end
        S_EXEC: begin
          state_q <= S_WB;
        end
        S_WB: begin
          if (ovf_trap) begin
            state_q <= S_ERR;
          end else begin
            count_q <= count_d;
            state_q <= S_FETCH;
          end
        end
        S_HALT:  state_q <= S_HALT;
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_ERR;
      endcase
    end
  end

endmodule
